// File: rtl/stride_update_engine_pkg.sv
// Shared types and stage-RAM entry layout for the stride lookup/update pipeline.
// Entry, LSB first: nexthop, hop_valid, child, plen.
package stride_update_engine_pkg;

  localparam int DEF_IDX_W     = 19;
  localparam int DEF_HOP_W     = 8;
  localparam int DEF_MAX_STAGE = 7;
  localparam int STAGE_W       = 3;
  localparam int STRIDE_W      = 4;
  localparam int PLEN_W        = 3;

  function automatic int valid_bit(input int hop_w);
    return hop_w;
  endfunction

  function automatic int child_lsb(input int hop_w);
    return hop_w + 1;
  endfunction

  function automatic int plen_lsb(input int idx_w, input int hop_w);
    return idx_w + hop_w + 1;
  endfunction

  function automatic int entry_w(input int idx_w, input int hop_w);
    return idx_w + hop_w + 1 + PLEN_W;
  endfunction

  typedef enum logic {
    OP_ROUTE = 1'b0,
    OP_CHILD = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_RD    = 3'd2,
    S_WAIT  = 3'd3,
    S_WR    = 3'd4,
    S_RESP  = 3'd5
  } state_e;

endpackage

// File: rtl/stride_update_engine_expand_range.sv
// Controlled prefix expansion inside one 4-bit stride: a len-bit prefix covers
// 2^(4-len) consecutive entries starting at the stride with its low bits cleared.
module stride_update_engine_expand_range
  import stride_update_engine_pkg::*;
(
  input  logic [PLEN_W-1:0]   len,
  input  logic [STRIDE_W-1:0] stride,
  output logic [STRIDE_W-1:0] base,
  output logic [STRIDE_W-1:0] count
);

  always_comb begin
    base  = stride;
    count = 4'd1;
    case (len)
      3'd1: begin
        base  = {stride[3], 3'b000};
        count = 4'd8;
      end
      3'd2: begin
        base  = {stride[3:2], 2'b00};
        count = 4'd4;
      end
      3'd3: begin
        base  = {stride[3:1], 1'b0};
        count = 4'd2;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/stride_update_engine.sv
// Route/child update engine: read-modify-write of stage-RAM entries, 3 cycles per entry,
// 2-cycle reject path. One command at a time; cmd_ready only in IDLE.
module stride_update_engine
  import stride_update_engine_pkg::*;
#(
  parameter int IDX_W     = DEF_IDX_W,
  parameter int HOP_W     = DEF_HOP_W,
  parameter int MAX_STAGE = DEF_MAX_STAGE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_op,
  input  logic [STAGE_W-1:0]       cmd_stage,
  input  logic [IDX_W-1:0]         cmd_node,
  input  logic [STRIDE_W-1:0]      cmd_stride,
  input  logic [PLEN_W-1:0]        cmd_len,
  input  logic [HOP_W-1:0]         cmd_nexthop,
  input  logic [IDX_W-1:0]         cmd_child,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [STAGE_W-1:0]       mem_stage,
  output logic [IDX_W+3:0]         mem_addr,
  output logic [IDX_W+HOP_W+3:0]   mem_wdata,
  input  logic [IDX_W+HOP_W+3:0]   mem_rdata,
  output logic                     done,
  output logic                     error,
  output logic                     busy
);

  localparam int EW = entry_w(IDX_W, HOP_W);
  localparam int VB = valid_bit(HOP_W);
  localparam int CL = child_lsb(HOP_W);
  localparam int PL = plen_lsb(IDX_W, HOP_W);

  state_e               state_q, state_d;
  op_e                  op_q;
  logic [STAGE_W-1:0]   stage_q;
  logic [IDX_W-1:0]     node_q, child_q;
  logic [STRIDE_W-1:0]  stride_q;
  logic [PLEN_W-1:0]    len_q;
  logic [HOP_W-1:0]     hop_q;
  logic [STRIDE_W-1:0]  base_q, base_d, cnt_q, cnt_d, k_q, k_d;
  logic [STRIDE_W-1:0]  exp_base, exp_cnt;

  logic                 en_d, we_d, done_d, error_d;
  logic [STAGE_W-1:0]   stage_d;
  logic [IDX_W+3:0]     addr_d;
  logic [EW-1:0]        wdata_d;

  logic                 bad;
  logic                 wr_ok;
  logic [EW-1:0]        wr_ent;

  logic [PLEN_W-1:0]    old_plen;
  logic [IDX_W-1:0]     old_child;
  logic                 old_vld;
  logic [HOP_W-1:0]     old_hop;

  assign old_plen  = mem_rdata[PL +: PLEN_W];
  assign old_child = mem_rdata[CL +: IDX_W];
  assign old_vld   = mem_rdata[VB];
  assign old_hop   = mem_rdata[0 +: HOP_W];

  stride_update_engine_expand_range u_expand_range (
    .len    (len_q),
    .stride (stride_q),
    .base   (exp_base),
    .count  (exp_cnt)
  );

  assign bad = (int'(stage_q) > MAX_STAGE)
             || ((stage_q == '0) && (node_q != '0))
             || ((op_q == OP_ROUTE) && ((len_q == 3'd0) || (len_q > 3'd4)));

  // Route inserts never displace a longer prefix; the child pointer always survives.
  always_comb begin
    wr_ok  = 1'b1;
    wr_ent = {old_plen, child_q, old_vld, old_hop};
    if (op_q == OP_ROUTE) begin
      wr_ok  = !old_vld || (old_plen <= len_q);
      wr_ent = {len_q, old_child, 1'b1, hop_q};
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    en_d    = 1'b0;
    we_d    = 1'b0;
    stage_d = '0;
    addr_d  = '0;
    wdata_d = '0;
    done_d  = 1'b0;
    error_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (bad) begin
          state_d = S_RESP;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else begin
          base_d  = (op_q == OP_CHILD) ? stride_q : exp_base;
          cnt_d   = (op_q == OP_CHILD) ? 4'd1 : exp_cnt;
          k_d     = '0;
          state_d = S_RD;
          en_d    = 1'b1;
          stage_d = stage_q;
          addr_d  = {node_q, base_d};
        end
      end
      S_RD: state_d = S_WAIT;
      S_WAIT: begin
        state_d = S_WR;
        if (wr_ok) begin
          en_d    = 1'b1;
          we_d    = 1'b1;
          stage_d = stage_q;
          addr_d  = {node_q, base_q | k_q};
          wdata_d = wr_ent;
        end
      end
      S_WR: begin
        if (k_q == cnt_q - 4'd1) begin
          state_d = S_RESP;
          done_d  = 1'b1;
        end else begin
          k_d     = k_q + 4'd1;
          state_d = S_RD;
          en_d    = 1'b1;
          stage_d = stage_q;
          addr_d  = {node_q, base_q | k_d};
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_ROUTE;
      stage_q   <= '0;
      node_q    <= '0;
      child_q   <= '0;
      stride_q  <= '0;
      len_q     <= '0;
      hop_q     <= '0;
      base_q    <= '0;
      cnt_q     <= '0;
      k_q       <= '0;
      cmd_ready <= 1'b1;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_stage <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      if (state_q == S_IDLE && cmd_valid) begin
        op_q     <= op_e'(cmd_op);
        stage_q  <= cmd_stage;
        node_q   <= cmd_node;
        child_q  <= cmd_child;
        stride_q <= cmd_stride;
        len_q    <= cmd_len;
        hop_q    <= cmd_nexthop;
      end
      cmd_ready <= (state_d == S_IDLE);
      busy      <= (state_d != S_IDLE) && (state_d != S_RESP);
      mem_en    <= en_d;
      mem_we    <= we_d;
      mem_stage <= stage_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      done      <= done_d;
      error     <= error_d;
    end
  end

endmodule

// File: tb/tb_stride_update_engine.sv
// Directed bench for stride_update_engine with a behavioural stage-RAM model.
module tb_stride_update_engine;

  localparam int IDX_W = 19;
  localparam int HOP_W = 8;
  localparam int EW    = IDX_W + HOP_W + 4;
  localparam int AW    = IDX_W + 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cmd_valid, cmd_ready, cmd_op;
  logic [2:0]           cmd_stage, cmd_len;
  logic [IDX_W-1:0]     cmd_node, cmd_child;
  logic [3:0]           cmd_stride;
  logic [HOP_W-1:0]     cmd_nexthop;
  logic                 mem_en, mem_we;
  logic [2:0]           mem_stage;
  logic [AW-1:0]        mem_addr;
  logic [EW-1:0]        mem_wdata, mem_rdata;
  logic                 done, error, busy;

  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  stride_update_engine #(.IDX_W(IDX_W), .HOP_W(HOP_W), .MAX_STAGE(5)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_stage(cmd_stage), .cmd_node(cmd_node), .cmd_stride(cmd_stride),
    .cmd_len(cmd_len), .cmd_nexthop(cmd_nexthop), .cmd_child(cmd_child),
    .mem_en(mem_en), .mem_we(mem_we), .mem_stage(mem_stage), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .done(done), .error(error), .busy(busy)
  );

  // Stage RAM model: registered read, unwritten entries read as zero.
  logic [EW-1:0]   ram [logic [AW+2:0]];
  logic [EW-1:0]   rdata_q = '0;
  logic [AW+2:0]   mkey;
  logic [AW+2:0]   last_wr_key = '0;
  int strobe_cnt = 0;
  int wr_cnt     = 0;
  int done_cnt   = 0;

  assign mkey      = {mem_stage, mem_addr};
  assign mem_rdata = rdata_q;

  always @(posedge clk) begin
    if (mem_en) begin
      strobe_cnt++;
      if (mem_we) begin
        wr_cnt++;
        ram[mkey]   = mem_wdata;
        last_wr_key = mkey;
      end else begin
        rdata_q <= ram.exists(mkey) ? ram[mkey] : '0;
      end
    end
    if (done) done_cnt++;
  end

  function automatic logic [EW-1:0] ent(input logic [2:0] plen, input logic [IDX_W-1:0] child,
                                        input logic v, input logic [HOP_W-1:0] hop);
    return {plen, child, v, hop};
  endfunction

  function automatic logic [EW-1:0] peek(input logic [2:0] st, input logic [IDX_W-1:0] node,
                                         input logic [3:0] e);
    logic [AW+2:0] k;
    k = {st, node, e};
    return ram.exists(k) ? ram[k] : '0;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int g;
    g = 0;
    while (!cmd_ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
  endtask

  task automatic drive(input logic op, input logic [2:0] st, input logic [IDX_W-1:0] node,
                       input logic [3:0] stride, input logic [2:0] len,
                       input logic [HOP_W-1:0] hop, input logic [IDX_W-1:0] child);
    cmd_op      = op;
    cmd_stage   = st;
    cmd_node    = node;
    cmd_stride  = stride;
    cmd_len     = len;
    cmd_nexthop = hop;
    cmd_child   = child;
    cmd_valid   = 1'b1;
    @(posedge clk); #1;
    cmd_valid   = 1'b0;
  endtask

  task automatic run_cmd(input string tag, input logic op, input logic [2:0] st,
                         input logic [IDX_W-1:0] node, input logic [3:0] stride,
                         input logic [2:0] len, input logic [HOP_W-1:0] hop,
                         input logic [IDX_W-1:0] child, input int exp_lat,
                         input logic exp_err, input int exp_strobes, input int exp_wr);
    int   lat, s0, w0;
    logic err;
    wait_ready();
    s0 = strobe_cnt;
    w0 = wr_cnt;
    drive(op, st, node, stride, len, hop, child);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_rdy_lo"}, cmd_ready, 0);
    lat = 1;
    while (!done && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    err = error;
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_strobes"}, strobe_cnt - s0, exp_strobes);
    check({tag, "_writes"}, wr_cnt - w0, exp_wr);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_rdy_back"}, cmd_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0, g;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 1'b0; cmd_stage = '0; cmd_node = '0; cmd_stride = '0;
    cmd_len = '0; cmd_nexthop = '0; cmd_child = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", cmd_ready, 1);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_stage", mem_stage, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // len=2 into an empty node: entries 8..11
    run_cmd("ins_l2", 0, 3'd1, 19'd3, 4'hA, 3'd2, 8'h11, 19'd0, 14, 0, 8, 4);
    for (int e = 8; e < 12; e++) check("ins_l2_ent", peek(3'd1, 19'd3, 4'(e)), ent(3'd2, '0, 1'b1, 8'h11));
    check("ins_l2_ent7", peek(3'd1, 19'd3, 4'd7), 0);
    check("ins_l2_ent12", peek(3'd1, 19'd3, 4'd12), 0);

    // len=1 covers 8..15; 8..11 hold a longer prefix and are skipped
    run_cmd("ins_l1", 0, 3'd1, 19'd3, 4'h8, 3'd1, 8'h05, 19'd0, 26, 0, 12, 4);
    for (int e = 12; e < 16; e++) check("ins_l1_new", peek(3'd1, 19'd3, 4'(e)), ent(3'd1, '0, 1'b1, 8'h05));
    for (int e = 8; e < 12; e++) check("ins_l1_keep", peek(3'd1, 19'd3, 4'(e)), ent(3'd2, '0, 1'b1, 8'h11));

    // child pointer update preserves route fields
    ram[{3'd2, 19'd7, 4'hC}] = ent(3'd3, '0, 1'b1, 8'h09);
    run_cmd("child", 1, 3'd2, 19'd7, 4'hC, 3'd0, 8'h00, 19'h1234, 5, 0, 2, 1);
    check("child_ent", peek(3'd2, 19'd7, 4'hC), ent(3'd3, 19'h1234, 1'b1, 8'h09));

    // route insert preserves child pointer
    run_cmd("ins_l4", 0, 3'd2, 19'd7, 4'hC, 3'd4, 8'h22, 19'd0, 5, 0, 2, 1);
    check("ins_l4_ent", peek(3'd2, 19'd7, 4'hC), ent(3'd4, 19'h1234, 1'b1, 8'h22));

    // len=3 over C,D: C keeps plen 4, D written; repeat with equal length overwrites D
    run_cmd("ins_l3", 0, 3'd2, 19'd7, 4'hD, 3'd3, 8'h44, 19'd0, 8, 0, 3, 1);
    check("ins_l3_c", peek(3'd2, 19'd7, 4'hC), ent(3'd4, 19'h1234, 1'b1, 8'h22));
    check("ins_l3_d", peek(3'd2, 19'd7, 4'hD), ent(3'd3, '0, 1'b1, 8'h44));
    run_cmd("ins_l3_eq", 0, 3'd2, 19'd7, 4'hC, 3'd3, 8'h55, 19'd0, 8, 0, 3, 1);
    check("ins_l3_eq_d", peek(3'd2, 19'd7, 4'hD), ent(3'd3, '0, 1'b1, 8'h55));

    // reject paths: no RAM traffic, done+error after 2 cycles
    run_cmd("st0_node1", 0, 3'd0, 19'd1, 4'hF, 3'd4, 8'h33, 19'd0, 2, 1, 0, 0);
    run_cmd("len0", 0, 3'd1, 19'd3, 4'h0, 3'd0, 8'h01, 19'd0, 2, 1, 0, 0);
    run_cmd("len5", 0, 3'd1, 19'd3, 4'h0, 3'd5, 8'h01, 19'd0, 2, 1, 0, 0);
    run_cmd("stage6", 0, 3'd6, 19'd0, 4'h0, 3'd4, 8'h01, 19'd0, 2, 1, 0, 0);
    run_cmd("stage7", 1, 3'd7, 19'd0, 4'h0, 3'd0, 8'h01, 19'd5, 2, 1, 0, 0);

    // legal boundaries: root node of stage 0, highest stage
    run_cmd("st0_node0", 0, 3'd0, 19'd0, 4'hF, 3'd4, 8'h33, 19'd0, 5, 0, 2, 1);
    check("st0_node0_key", last_wr_key, {3'd0, 19'd0, 4'hF});
    check("st0_node0_ent", peek(3'd0, 19'd0, 4'hF), ent(3'd4, '0, 1'b1, 8'h33));
    run_cmd("stage5", 1, 3'd5, 19'd2, 4'h3, 3'd0, 8'h00, 19'h42, 5, 0, 2, 1);
    check("stage5_ent", peek(3'd5, 19'd2, 4'h3), ent(3'd0, 19'h42, 1'b0, 8'h00));

    // reset in the middle of a len=1 insert after three writes
    wait_ready();
    drive(0, 3'd3, 19'd9, 4'h0, 3'd1, 8'h07, 19'd0);
    w0 = wr_cnt;
    d0 = done_cnt;
    g  = 0;
    while ((wr_cnt - w0) < 3 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    check("abort_pre_writes", wr_cnt - w0, 3);
    rst = 1'b1;
    #1;
    check("abort_mem_en", mem_en, 0);
    check("abort_ready", cmd_ready, 1);
    check("abort_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_writes", wr_cnt - w0, 3);
    for (int e = 0; e < 3; e++) check("abort_kept", peek(3'd3, 19'd9, 4'(e)), ent(3'd1, '0, 1'b1, 8'h07));
    check("abort_ent3", peek(3'd3, 19'd9, 4'd3), 0);

    run_cmd("after_rst", 0, 3'd3, 19'd9, 4'h4, 3'd2, 8'h08, 19'd0, 14, 0, 8, 4);
    for (int e = 4; e < 8; e++) check("after_rst_ent", peek(3'd3, 19'd9, 4'(e)), ent(3'd2, '0, 1'b1, 8'h08));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
